// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the mul/div and ALU/mem write-back streams onto one register-file write port.
// Mul/div results always win; colliding ALU results wait in a skid FIFO while stall_o is raised.
// Optional feature: define WB_BYPASS_EN to enable rs1/rs2 bypass lookups into the FIFO and write port.
module wb_arbiter #(
    parameter int WD_SIZE        = 32,
    parameter int INSTR_REG_SIZE = 5,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      alu_valid_i,
    input  logic                      alu_reg_write_i,
    input  logic [INSTR_REG_SIZE-1:0] alu_rd_i,
    input  logic [WD_SIZE-1:0]        alu_result_i,
    input  logic                      mul_valid_i,
    input  logic                      mul_reg_write_i,
    input  logic [INSTR_REG_SIZE-1:0] mul_rd_i,
    input  logic [WD_SIZE-1:0]        mul_result_i,
    input  logic [INSTR_REG_SIZE-1:0] rs1_i,
    input  logic [INSTR_REG_SIZE-1:0] rs2_i,
    output logic                      rf_we_o,
    output logic [INSTR_REG_SIZE-1:0] rf_waddr_o,
    output logic [WD_SIZE-1:0]        rf_wdata_o,
    output logic                      stall_o,
    output logic                      overflow_o,
    output logic                      fwd1_hit_o,
    output logic                      fwd2_hit_o,
    output logic [WD_SIZE-1:0]        fwd1_data_o,
    output logic [WD_SIZE-1:0]        fwd2_data_o
);
    localparam int           PW   = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]  FULL = (PW+1)'(FIFO_DEPTH);

    logic [INSTR_REG_SIZE-1:0] q_rd [FIFO_DEPTH];
    logic [WD_SIZE-1:0]        q_data [FIFO_DEPTH];
    logic [PW-1:0]             head, tail;
    logic [PW:0]               count, count_next;
    logic                      mul_live, alu_live, occupied, pop, push, push_ok, sel_we;
    logic [INSTR_REG_SIZE-1:0] sel_rd;
    logic [WD_SIZE-1:0]        sel_data;

    assign mul_live = mul_valid_i && mul_reg_write_i && mul_rd_i != '0;
    assign alu_live = alu_valid_i && alu_reg_write_i && alu_rd_i != '0;
    assign occupied = count != '0;

    // Pick the write source (mul > FIFO head > direct ALU) and decide FIFO movement
    always_comb begin
        pop        = occupied && !mul_live;
        push       = alu_live && (mul_live || occupied);
        push_ok    = push && (count != FULL || pop);
        count_next = count + (PW+1)'(push_ok) - (PW+1)'(pop);
        sel_we     = mul_live || occupied || alu_live;
        sel_rd     = mul_live ? mul_rd_i : (occupied ? q_rd[head] : alu_rd_i);
        sel_data   = mul_live ? mul_result_i : (occupied ? q_data[head] : alu_result_i);
    end

    // Control state and the registered write port; reset drops all FIFO contents at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            stall_o    <= 1'b0;
            overflow_o <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            if (push && !push_ok) overflow_o <= 1'b1;
            count   <= count_next;
            stall_o <= count_next != '0;
            rf_we_o <= sel_we;
            if (sel_we) begin
                rf_waddr_o <= sel_rd;
                rf_wdata_o <= sel_data;
            end
        end
    end

    // FIFO storage; entries are only meaningful while counted, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_rd[tail]   <= alu_rd_i;
            q_data[tail] <= alu_result_i;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] idx;

    // Bypass lookup: the write port is the oldest candidate, the FIFO is scanned oldest to youngest so the youngest match wins
    always_comb begin
        idx         = head;
        fwd1_hit_o  = rs1_i != '0 && rf_we_o && rf_waddr_o == rs1_i;
        fwd2_hit_o  = rs2_i != '0 && rf_we_o && rf_waddr_o == rs2_i;
        fwd1_data_o = fwd1_hit_o ? rf_wdata_o : '0;
        fwd2_data_o = fwd2_hit_o ? rf_wdata_o : '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = head + PW'(i);
            if (i < int'(count) && rs1_i != '0 && q_rd[idx] == rs1_i) begin
                fwd1_hit_o  = 1'b1;
                fwd1_data_o = q_data[idx];
            end
            if (i < int'(count) && rs2_i != '0 && q_rd[idx] == rs2_i) begin
                fwd2_hit_o  = 1'b1;
                fwd2_data_o = q_data[idx];
            end
        end
    end
`else
    logic unused_rs;

    assign unused_rs   = ^{rs1_i, rs2_i};
    assign fwd1_hit_o  = 1'b0;
    assign fwd2_hit_o  = 1'b0;
    assign fwd1_data_o = '0;
    assign fwd2_data_o = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter; a queue-based reference model predicts every write.
module tb_wb_arbiter;
    localparam int WD    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          alu_valid_i, alu_reg_write_i, mul_valid_i, mul_reg_write_i;
    logic [RW-1:0] alu_rd_i, mul_rd_i, rs1_i, rs2_i;
    logic [WD-1:0] alu_result_i, mul_result_i;
    logic          rf_we_o, stall_o, overflow_o, fwd1_hit_o, fwd2_hit_o;
    logic [RW-1:0] rf_waddr_o;
    logic [WD-1:0] rf_wdata_o, fwd1_data_o, fwd2_data_o;

    always #5 clk = ~clk;

    wb_arbiter #(.WD_SIZE(WD), .INSTR_REG_SIZE(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid_i(alu_valid_i), .alu_reg_write_i(alu_reg_write_i),
        .alu_rd_i(alu_rd_i), .alu_result_i(alu_result_i),
        .mul_valid_i(mul_valid_i), .mul_reg_write_i(mul_reg_write_i),
        .mul_rd_i(mul_rd_i), .mul_result_i(mul_result_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .stall_o(stall_o), .overflow_o(overflow_o),
        .fwd1_hit_o(fwd1_hit_o), .fwd2_hit_o(fwd2_hit_o),
        .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o)
    );

    typedef struct {
        int            tag;
        logic [RW-1:0] rd;
        logic [WD-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           pend[$];
    int            cyc = 0;
    int            checks = 0;
    int            fails = 0;
    logic          m_stall = 1'b0, m_ovf = 1'b0, m_we = 1'b0;
    logic [RW-1:0] m_rd = '0;
    logic [WD-1:0] m_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected bypass result {hit, data}: youngest queued entry first, then the last write
    function automatic logic [WD:0] lookup(input logic [RW-1:0] rs);
`ifdef WB_BYPASS_EN
        if (rs == '0) return '0;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].rd == rs) return {1'b1, pend[i].data};
        if (m_we && m_rd == rs) return {1'b1, m_data};
`endif
        return '0;
    endfunction

    function automatic void emit(input logic [RW-1:0] rd, input logic [WD-1:0] data);
        exp_q.push_back('{tag: cyc, rd: rd, data: data});
        m_we   = 1'b1;
        m_rd   = rd;
        m_data = data;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: pending ALU results kept as a plain queue with a capacity of DEPTH
    always @(posedge clk) begin : model
        logic mul_l, alu_l, had;
        wr_t  h;
        if (!reset_n) begin
            pend.delete();
            exp_q.delete();
            m_stall = 1'b0;
            m_ovf   = 1'b0;
            m_we    = 1'b0;
        end else begin
            mul_l = mul_valid_i && mul_reg_write_i && mul_rd_i != 0;
            alu_l = alu_valid_i && alu_reg_write_i && alu_rd_i != 0;
            had   = pend.size() != 0;
            m_we  = 1'b0;
            if (mul_l) emit(mul_rd_i, mul_result_i);
            else if (had) begin
                h = pend.pop_front();
                emit(h.rd, h.data);
            end else if (alu_l) emit(alu_rd_i, alu_result_i);
            if (alu_l && (mul_l || had)) begin
                if (pend.size() < DEPTH) pend.push_back('{tag: cyc, rd: alu_rd_i, data: alu_result_i});
                else m_ovf = 1'b1;
            end
            m_stall = pend.size() != 0;
        end
    end

    // Monitor: pops the scoreboard whenever a write is due and compares every output
    always @(posedge clk) begin : monitor
        wr_t           e;
        logic          due;
        logic [WD:0]   f1, f2;
        #1;
        if (reset_n) begin
            due = exp_q.size() != 0 && exp_q[0].tag == cyc - 1;
            chk("rf_we", rf_we_o, due);
            if (due) begin
                e = exp_q.pop_front();
                if (rf_we_o) begin
                    chk("rf_waddr", rf_waddr_o, e.rd);
                    chk("rf_wdata", rf_wdata_o, e.data);
                end
            end
            chk("stall", stall_o, m_stall);
            chk("overflow", overflow_o, m_ovf);
            f1 = lookup(rs1_i);
            f2 = lookup(rs2_i);
            chk("fwd1", {fwd1_hit_o, fwd1_data_o}, f1);
            chk("fwd2", {fwd2_hit_o, fwd2_data_o}, f2);
        end
    end

    task automatic drive(input logic av, aw, input logic [RW-1:0] ard, input logic [WD-1:0] ares,
                         input logic mv, mw, input logic [RW-1:0] mrd, input logic [WD-1:0] mres);
        @(negedge clk);
        alu_valid_i = av; alu_reg_write_i = aw; alu_rd_i = ard; alu_result_i = ares;
        mul_valid_i = mv; mul_reg_write_i = mw; mul_rd_i = mrd; mul_result_i = mres;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_we"}, rf_we_o, 0);
        chk({tag, "_waddr"}, rf_waddr_o, 0);
        chk({tag, "_wdata"}, rf_wdata_o, 0);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_overflow"}, overflow_o, 0);
        chk({tag, "_fwd_hits"}, {fwd1_hit_o, fwd2_hit_o}, 0);
    endtask

    initial begin
        int   gap;
        logic mv;
        {alu_valid_i, alu_reg_write_i, mul_valid_i, mul_reg_write_i} = '0;
        {alu_rd_i, mul_rd_i, rs1_i, rs2_i} = '0;
        {alu_result_i, mul_result_i} = '0;
        repeat (3) @(posedge clk);
        #2 chk_zero_outputs("reset");
        @(negedge clk) reset_n = 1'b1;

        // lone ALU write
        drive(1, 1, 5'd5, 32'h11, 0, 0, '0, '0);
        @(posedge clk); #2;
        chk("lone_we", rf_we_o, 1);
        chk("lone_waddr", rf_waddr_o, 5);
        chk("lone_wdata", rf_wdata_o, 32'h11);
        chk("lone_stall", stall_o, 0);
        idle(2);

        // collision: mul x3 first, ALU x4 from the FIFO
        drive(1, 1, 5'd4, 32'hBB, 1, 1, 5'd3, 32'hAA);
        @(posedge clk); #2;
        chk("coll_waddr1", rf_waddr_o, 3);
        chk("coll_wdata1", rf_wdata_o, 32'hAA);
        chk("coll_stall1", stall_o, 1);
        idle(1);
        @(posedge clk); #2;
        chk("coll_waddr2", rf_waddr_o, 4);
        chk("coll_wdata2", rf_wdata_o, 32'hBB);
        idle(1);
        @(posedge clk); #2;
        chk("coll_stall3", stall_o, 0);
        idle(2);

        // same destination: mul value lands first, ALU value second
        drive(1, 1, 5'd7, 32'd2, 1, 1, 5'd7, 32'd1);
        @(posedge clk); #2;
        chk("same_rd_first", {rf_waddr_o, rf_wdata_o}, {5'd7, 32'd1});
        idle(1);
        @(posedge clk); #2;
        chk("same_rd_second", {rf_waddr_o, rf_wdata_o}, {5'd7, 32'd2});
        idle(2);

        // x0 destination and reg_write=0 are discarded
        drive(1, 1, 5'd0, 32'h33, 1, 0, 5'd6, 32'h44);
        @(posedge clk); #2;
        chk("filter_we", rf_we_o, 0);
        chk("filter_stall", stall_o, 0);
        idle(2);

        // bypass from a queued entry
        rs1_i = 5'd9; rs2_i = 5'd0;
        drive(1, 1, 5'd9, 32'h5, 1, 1, 5'd3, 32'h77);
        @(posedge clk); #2;
`ifdef WB_BYPASS_EN
        chk("byp_fwd1", {fwd1_hit_o, fwd1_data_o}, {1'b1, 32'h5});
`else
        chk("byp_fwd1", {fwd1_hit_o, fwd1_data_o}, 0);
`endif
        chk("byp_fwd2_hit", fwd2_hit_o, 0);
        idle(3);

        // random traffic obeying the stall and mul-rate rules
        gap = 10;
        repeat (400) begin
            @(negedge clk);
            mv = gap >= 5 && $urandom_range(0, 2) == 0;
            gap = mv ? 0 : gap + 1;
            alu_valid_i     = !stall_o && $urandom_range(0, 1) == 1;
            alu_reg_write_i = $urandom_range(0, 7) != 0;
            alu_rd_i        = RW'($urandom_range(0, 15));
            alu_result_i    = $urandom;
            mul_valid_i     = mv;
            mul_reg_write_i = $urandom_range(0, 7) != 0;
            mul_rd_i        = RW'($urandom_range(0, 15));
            mul_result_i    = $urandom;
            rs1_i           = RW'($urandom_range(0, 15));
            rs2_i           = RW'($urandom_range(0, 15));
        end
        idle(4);

        // overflow: three pushes with no pop, third ALU entry dropped
        drive(1, 1, 5'd1, 32'h101, 1, 1, 5'd2, 32'h201);
        drive(1, 1, 5'd3, 32'h103, 1, 1, 5'd4, 32'h204);
        drive(1, 1, 5'd5, 32'h105, 1, 1, 5'd6, 32'h206);
        @(posedge clk); #2;
        chk("ovf_set", overflow_o, 1);
        idle(5);
        @(posedge clk); #2;
        chk("ovf_sticky", overflow_o, 1);

        // asynchronous reset mid-stream with a FIFO entry queued
        drive(1, 1, 5'd8, 32'h88, 1, 1, 5'd10, 32'hA0);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1 chk_zero_outputs("async_rst");
        idle(2);
        @(negedge clk) reset_n = 1'b1;
        drive(1, 1, 5'd12, 32'hC0, 0, 0, '0, '0);
        idle(4);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly downstream of the multi-cycle multiply/divide stage and the single-cycle ALU/memory path. It merges both result streams onto the one register-file write port. Multiply results have absolute priority because that stage cannot be stalled. Colliding ALU results go into a small skid FIFO, and a stall is raised to the issue stage while the FIFO is occupied.

## Interface
Parameters:
- WD_SIZE, 32, data word width
- INSTR_REG_SIZE, 5, register index width
- FIFO_DEPTH, 2, ALU skid FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU/mem result valid this cycle
- alu_reg_write_i  in  1  ALU result writes register file
- alu_rd_i  in  INSTR_REG_SIZE  ALU destination
- alu_result_i  in  WD_SIZE  ALU result
- mul_valid_i  in  1  mul/div result valid (one-cycle pulse)
- mul_reg_write_i  in  1  mul/div result writes register file
- mul_rd_i  in  INSTR_REG_SIZE  mul/div destination
- mul_result_i  in  WD_SIZE  mul/div result
- rs1_i, rs2_i  in  INSTR_REG_SIZE  decode source indices (bypass lookup)
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  INSTR_REG_SIZE  write address (registered)
- rf_wdata_o  out  WD_SIZE  write data (registered)
- stall_o  out  1  issue stall, high while FIFO non-empty (registered)
- overflow_o  out  1  sticky error: push attempted while full
- fwd1_hit_o, fwd2_hit_o  out  1  bypass hit for rs1/rs2
- fwd1_data_o, fwd2_data_o  out  WD_SIZE  bypass data

## Operation
- Qualification: a request is live only if valid & reg_write & rd != 0. Non-live requests are discarded and never enter the FIFO.
- Selection for the write in the next cycle, priority order:
  1. live mul request
  2. FIFO head (pop)
  3. live ALU request (direct, no FIFO)
- A live ALU request is pushed to the FIFO tail when a live mul request is present or the FIFO is non-empty. Pop and push in the same cycle are allowed; order is preserved.
- Ordering guarantee: stall_o blocks all issue, so FIFO entries are always younger than any arriving mul result. Writing mul first is therefore architecturally correct, including when both target the same rd.
- FIFO: circular buffer with head/tail pointers wrapping modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
- Push while count == FIFO_DEPTH with no simultaneous pop: the entry is dropped, overflow_o sets, and it stays set until reset.
- stall_o is loaded with (count_next != 0).
- Reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, stall_o=0, overflow_o=0, count=0, pointers=0, fwd hits=0. Reset mid-operation discards all FIFO contents immediately.

## Timing
- Latency from a selected input to rf_we_o is 1 cycle.
- ALU delay equals 1 cycle + queue position when buffered. Worst case per queued entry is one extra cycle per competing mul pulse.
- stall_o rises the cycle after the first push and falls the cycle after the pop that empties the FIFO.
- Upstream must deassert alu_valid_i in any cycle where stall_o=1. The one request in flight when stall rises is absorbed by the FIFO (depth ≥2).
- The mul stage produces at most one result per 5 cycles, so the FIFO always drains between mul pulses.

## Configuration
- WB_BYPASS_EN defined: fwdN_hit_o/fwdN_data_o are combinational lookups on rsN_i (rsN_i != 0). Search order: youngest FIFO entry first, then older FIFO entries, then the registered write port (rf_we_o/rf_waddr_o). First match wins.
- WB_BYPASS_EN undefined: no lookup logic; hit outputs are tied 0 and data outputs tied 0.

## Test plan
- Lone ALU write: alu_valid=1, rd=5, data=0x11 → next cycle rf_we=1, waddr=5, wdata=0x11; stall_o stays 0.
- Collision: mul rd=3 data=0xAA and ALU rd=4 data=0xBB in the same cycle.
  - cycle+1: write x3=0xAA, stall_o=1
  - cycle+2: write x4=0xBB
  - cycle+3: stall_o=0
- Same-rd collision: mul rd=7 data=1 and ALU rd=7 data=2 in the same cycle → writes x7=1, then x7=2.
- x0/no-write filtering: ALU rd=0, and mul with reg_write=0 → rf_we stays 0, FIFO stays empty.
- Overflow: force three pushes with no pop (alu_valid held while a mul pulse collides) → third entry dropped, overflow_o=1 and sticky; assert reset_n low mid-stream → all outputs 0 asynchronously.
- Bypass (WB_BYPASS_EN): FIFO holds rd=9 data=0x5, rs1_i=9 → fwd1_hit=1, fwd1_data=0x5; rs2_i=0 → fwd2_hit=0.
